// File: rtl/uart_fifo_if.sv
// uart_fifo_if: register bus between the core and the UART.
// master drives strobes, address and write data; slave returns read data.
interface uart_fifo_if;
  logic        we_i;
  logic        re_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output we_i, re_i, addr_i, data_i,
    input  data_o
  );

  modport slave (
    input  we_i, re_i, addr_i, data_i,
    output data_o
  );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: FIFO-buffered UART with parity, stop-bit and error reporting.
// Define UART_IRQ_EN to add the IRQ_EN register (0x14) and irq_o.
module uart_fifo #(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter logic [31:0] BAUD_RST = 32'h1B8
) (
  input  logic       clk,
  input  logic       rst,
  uart_fifo_if.slave bus,
  output logic       tx_pin,
  input  logic       rx_pin
`ifdef UART_IRQ_EN
  ,
  output logic       irq_o
`endif
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  logic [7:0] a;
  logic sel_ctrl, sel_stat, sel_baud;
  logic sel_txd, sel_rxd, sel_irq;
  logic wr_ctrl, wr_stat, wr_baud;
  assign a        = bus.addr_i[7:0];
  assign sel_ctrl = a == 8'h00;
  assign sel_stat = a == 8'h04;
  assign sel_baud = a == 8'h08;
  assign sel_txd  = a == 8'h0C;
  assign sel_rxd  = a == 8'h10;
  assign sel_irq  = a == 8'h14;
  assign wr_ctrl  = bus.we_i & sel_ctrl;
  assign wr_stat  = bus.we_i & sel_stat;
  assign wr_baud  = bus.we_i & sel_baud;

  logic unused_ok;
  assign unused_ok = ^{bus.addr_i[31:8],
                       bus.data_i[31:16], sel_irq};

  logic [4:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d, deff;
  logic [2:0]  err_q, err_d;
  logic        tx_flush, rx_flush;
  logic        set_frm, set_par, set_ovr;

  assign deff     = (baud_q < 16'd4) ? 16'd4 : baud_q;
  assign tx_flush = wr_ctrl & bus.data_i[5];
  assign rx_flush = wr_ctrl & bus.data_i[6];
  assign ctrl_d   = wr_ctrl ? bus.data_i[4:0] : ctrl_q;
  assign baud_d   = wr_baud ? bus.data_i[15:0] : baud_q;
  // a new error in the same cycle as the w1c write keeps the flag set
  assign err_d = (err_q & ~(wr_stat ? bus.data_i[7:5] : 3'b0))
               | {set_frm, set_par, set_ovr};

  logic [7:0]   txm [TX_DEPTH];
  logic [TAW:0] txw_q, txw_d, txr_q, txr_d;
  logic         tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]   tx_head;

  assign tx_empty = txw_q == txr_q;
  assign tx_full  = (txw_q[TAW] != txr_q[TAW]) &&
                    (txw_q[TAW-1:0] == txr_q[TAW-1:0]);
  assign tx_head  = txm[txr_q[TAW-1:0]];
  assign tx_push  = bus.we_i & sel_txd & ctrl_q[0] & ~tx_full;

  always_comb begin
    txw_d = txw_q + {{TAW{1'b0}}, tx_push};
    txr_d = txr_q + {{TAW{1'b0}}, tx_pop};
    if (tx_flush) begin
      txw_d = '0;
      txr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) txm[txw_q[TAW-1:0]] <= bus.data_i[7:0];
  end

  logic [7:0]   rxm [RX_DEPTH];
  logic [RAW:0] rxw_q, rxw_d, rxr_q, rxr_d;
  logic         rx_full, rx_empty, rx_push, rx_pop, rx_try;
  logic [8:0]   rx_cnt9;

  assign rx_empty = rxw_q == rxr_q;
  assign rx_full  = (rxw_q[RAW] != rxr_q[RAW]) &&
                    (rxw_q[RAW-1:0] == rxr_q[RAW-1:0]);
  assign rx_cnt9  = 9'(rxw_q - rxr_q);
  assign rx_pop   = bus.re_i & sel_rxd & ~rx_empty;
  assign rx_push  = rx_try & (~rx_full | rx_pop);
  assign set_ovr  = rx_try & rx_full & ~rx_pop;

  always_comb begin
    rxw_d = rxw_q + {{RAW{1'b0}}, rx_push};
    rxr_d = rxr_q + {{RAW{1'b0}}, rx_pop};
    if (rx_flush) begin
      rxw_d = '0;
      rxr_d = '0;
    end
  end

  state_e      tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d, tx_par_q, tx_par_d;
  logic        tx_pen_q, tx_pen_d, tx_s2_q, tx_s2_d;
  logic        tx_snd_q, tx_snd_d, tx_end, tx_load;

  assign tx_end = tx_cnt_q == tx_div_q;
  assign tx_pin = tx_q;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    tx_sh_d  = tx_sh_q;
    tx_bit_d = tx_bit_q;
    tx_d     = tx_q;
    tx_par_d = tx_par_q;
    tx_pen_d = tx_pen_q;
    tx_s2_d  = tx_s2_q;
    tx_snd_d = tx_snd_q;
    tx_load  = 1'b0;
    tx_pop   = 1'b0;
    if (tx_st_q != S_IDLE)
      tx_cnt_d = tx_end ? 16'd0 : tx_cnt_q + 16'd1;
    unique case (tx_st_q)
      S_IDLE: tx_load = ctrl_q[0] & ~tx_empty;
      S_START: if (tx_end) begin
        tx_st_d  = S_DATA;
        tx_d     = tx_sh_q[0];
        tx_bit_d = 3'd0;
      end
      S_DATA: if (tx_end) begin
        if (tx_bit_q == 3'd7) begin
          tx_st_d  = tx_pen_q ? S_PAR : S_STOP;
          tx_d     = tx_pen_q ? tx_par_q : 1'b1;
          tx_snd_d = 1'b0;
        end else begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_d     = tx_sh_q[1];
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      S_PAR: if (tx_end) begin
        tx_st_d = S_STOP;
        tx_d    = 1'b1;
      end
      S_STOP: if (tx_end) begin
        if (tx_s2_q && !tx_snd_q) begin
          tx_snd_d = 1'b1;
        end else begin
          tx_st_d = S_IDLE;
          tx_load = ctrl_q[0] & ~tx_empty;
        end
      end
      default: tx_st_d = S_IDLE;
    endcase
    // frame format and divider are frozen for the whole frame
    if (tx_load) begin
      tx_pop   = 1'b1;
      tx_st_d  = S_START;
      tx_d     = 1'b0;
      tx_cnt_d = 16'd0;
      tx_sh_d  = tx_head;
      tx_par_d = (^tx_head) ^ ctrl_q[3];
      tx_div_d = deff;
      tx_pen_d = ctrl_q[2];
      tx_s2_d  = ctrl_q[4];
    end
  end

  state_e      rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_s1_q, rx_s2_q, rx_p_q;
  logic        rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
  logic        rx_pe_q, rx_pe_d, rx_smp;

  assign rx_smp = (rx_st_q == S_START)
                ? (rx_cnt_q == {1'b0, rx_div_q[15:1]})
                : (rx_cnt_q == rx_div_q);

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_div_d = rx_div_q;
    rx_sh_d  = rx_sh_q;
    rx_bit_d = rx_bit_q;
    rx_pen_d = rx_pen_q;
    rx_odd_d = rx_odd_q;
    rx_pe_d  = rx_pe_q;
    rx_try   = 1'b0;
    set_frm  = 1'b0;
    set_par  = 1'b0;
    if (rx_st_q != S_IDLE)
      rx_cnt_d = rx_smp ? 16'd0 : rx_cnt_q + 16'd1;
    if (!ctrl_q[1]) begin
      rx_st_d = S_IDLE;
    end else begin
      unique case (rx_st_q)
        S_IDLE: if (rx_p_q && !rx_s2_q) begin
          rx_st_d  = S_START;
          rx_cnt_d = 16'd1;
          rx_div_d = deff;
          rx_pen_d = ctrl_q[2];
          rx_odd_d = ctrl_q[3];
          rx_pe_d  = 1'b0;
        end
        S_START: if (rx_smp) begin
          rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
          rx_bit_d = 3'd0;
        end
        S_DATA: if (rx_smp) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7)
            rx_st_d = rx_pen_q ? S_PAR : S_STOP;
        end
        S_PAR: if (rx_smp) begin
          rx_pe_d = rx_s2_q != ((^rx_sh_q) ^ rx_odd_q);
          rx_st_d = S_STOP;
        end
        S_STOP: if (rx_smp) begin
          rx_st_d = S_IDLE;
          rx_try  = 1'b1;
          set_frm = ~rx_s2_q;
          set_par = rx_pe_q;
        end
        default: rx_st_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rxm[rxw_q[RAW-1:0]] <= rx_sh_q;
  end

  logic [2:0] irqen_q, irqen_d;
`ifdef UART_IRQ_EN
  logic irq_q, irq_d;
  assign irqen_d = (bus.we_i & sel_irq) ? bus.data_i[2:0] : irqen_q;
  assign irq_d   = |(irqen_q & {|err_q, tx_empty, ~rx_empty});
  assign irq_o   = irq_q;
  always_ff @(posedge clk) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= irq_d;
  end
`else
  assign irqen_d = 3'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q   <= '0;
      baud_q   <= BAUD_RST[15:0];
      err_q    <= '0;
      irqen_q  <= '0;
      txw_q    <= '0;
      txr_q    <= '0;
      rxw_q    <= '0;
      rxr_q    <= '0;
      tx_st_q  <= S_IDLE;
      tx_q     <= 1'b1;
      tx_cnt_q <= '0;
      tx_div_q <= '0;
      tx_sh_q  <= '0;
      tx_bit_q <= '0;
      tx_par_q <= 1'b0;
      tx_pen_q <= 1'b0;
      tx_s2_q  <= 1'b0;
      tx_snd_q <= 1'b0;
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_div_q <= '0;
      rx_sh_q  <= '0;
      rx_bit_q <= '0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_p_q   <= 1'b1;
      rx_pen_q <= 1'b0;
      rx_odd_q <= 1'b0;
      rx_pe_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      baud_q   <= baud_d;
      err_q    <= err_d;
      irqen_q  <= irqen_d;
      txw_q    <= txw_d;
      txr_q    <= txr_d;
      rxw_q    <= rxw_d;
      rxr_q    <= rxr_d;
      tx_st_q  <= tx_st_d;
      tx_q     <= tx_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_sh_q  <= tx_sh_d;
      tx_bit_q <= tx_bit_d;
      tx_par_q <= tx_par_d;
      tx_pen_q <= tx_pen_d;
      tx_s2_q  <= tx_s2_d;
      tx_snd_q <= tx_snd_d;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_sh_q  <= rx_sh_d;
      rx_bit_q <= rx_bit_d;
      rx_s1_q  <= rx_pin;
      rx_s2_q  <= rx_s1_q;
      rx_p_q   <= rx_s2_q;
      rx_pen_q <= rx_pen_d;
      rx_odd_q <= rx_odd_d;
      rx_pe_q  <= rx_pe_d;
    end
  end

  logic [31:0] rdata;
  always_comb begin
    rdata = 32'h0;
    unique case (1'b1)
      sel_ctrl: rdata = {27'h0, ctrl_q};
      sel_stat: rdata = {16'h0, rx_cnt9[7:0], err_q,
                         rx_full, rx_empty, tx_empty,
                         tx_full, tx_st_q != S_IDLE};
      sel_baud: rdata = {16'h0, baud_q};
      sel_rxd:  rdata = rx_empty ? 32'h0
                      : {24'h0, rxm[rxr_q[RAW-1:0]]};
`ifdef UART_IRQ_EN
      sel_irq:  rdata = {29'h0, irqen_q};
`endif
      default:  rdata = 32'h0;
    endcase
  end

  assign bus.data_o = rst ? rdata : 32'h0;
endmodule
